// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} resp_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] chain;
    logic            prev;

    // No reset: after a local reset the chain must still reflect the live pin,
    // so a select that stays high is not mistaken for a fresh frame start.
    always_ff @(posedge clk) begin
        chain <= {chain[SYNC-2:0], d};
        prev  <= chain[SYNC-1];
    end

    assign q    = chain[SYNC-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a byte-wide register file with auto-incrementing bursts.
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int ID   = 0,
    parameter int AW   = 3,
    parameter int SYNC = 2
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    input  logic [1:0]            ss_i,
    output logic                  miso_o,
    input  logic                  lw_en_i,
    input  logic [AW-1:0]         lw_addr_i,
    input  logic [SPI_BYTE_W-1:0] lw_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [SPI_BYTE_W-1:0] rd_data_o,
    output logic                  wr_pulse_o,
    output logic [AW-1:0]         wr_addr_o,
    output logic [SPI_BYTE_W-1:0] wr_data_o,
    output logic                  busy_o
);

    localparam int         DEPTH = 2**AW;
    localparam int         BCW   = $clog2(SPI_BYTE_W);
    localparam logic [1:0] SEL   = 2'(1 << ID);

    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic ss_s, ss_rise, ss_fall;
    logic sel_raw;
    logic unused_sync;

    // Only a clean one-hot select of our bit counts; a multi-select bus is ignored.
    assign sel_raw = (ss_i == SEL);

    spi_sync #(.SYNC(SYNC)) u_sync_sck  (.clk(Clk_i), .d(sck_i),   .q(sck_s),  .rise(sck_rise),  .fall(sck_fall));
    spi_sync #(.SYNC(SYNC)) u_sync_mosi (.clk(Clk_i), .d(mosi_i),  .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
    spi_sync #(.SYNC(SYNC)) u_sync_ss   (.clk(Clk_i), .d(sel_raw), .q(ss_s),   .rise(ss_rise),   .fall(ss_fall));

    assign unused_sync = &{1'b0, mosi_rise, mosi_fall, sck_s, ss_s};

    resp_state_t                  state;
    logic [BCW-1:0]               bit_cnt;
    logic [AW-1:0]                addr;
    logic [SPI_BYTE_W-2:0]        shift_in;
    logic [SPI_BYTE_W-1:0]        shift_out;
    logic [SPI_BYTE_W-1:0]        rx_byte;
    logic                         last_bit;
    logic [SPI_BYTE_W-1:0]        regs [DEPTH];

    assign rx_byte  = {shift_in, mosi_s};
    assign last_bit = (bit_cnt == BCW'(SPI_BYTE_W - 1));

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            state      <= IDLE;
            bit_cnt    <= '0;
            addr       <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            wr_pulse_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
        end else begin
            wr_pulse_o <= 1'b0;
            // Local write goes first so a same-address SPI commit below overrides it.
            if (lw_en_i) regs[lw_addr_i] <= lw_data_i;

            if (ss_fall) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_rise) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte[SPI_BYTE_W-2:0];
                            bit_cnt  <= bit_cnt + BCW'(1);
                            if (last_bit) begin
                                addr      <= rx_byte[AW-1:0];
                                shift_out <= '0;
                                state     <= rx_byte[CMD_RW_BIT] ? RDATA : WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte[SPI_BYTE_W-2:0];
                            bit_cnt  <= bit_cnt + BCW'(1);
                            if (last_bit) begin
                                regs[addr] <= rx_byte;
                                wr_pulse_o <= 1'b1;
                                wr_addr_o  <= addr;
                                wr_data_o  <= rx_byte;
                                addr       <= addr + AW'(1);
                            end
                        end
                    end
                    RDATA: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            if (last_bit) addr <= addr + AW'(1);
                        end else if (sck_fall) begin
                            // Byte boundary reloads from the current address; otherwise shift.
                            shift_out <= (bit_cnt == '0) ? regs[addr]
                                                         : {shift_out[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rd_data_o = regs[rd_addr_i];
    assign busy_o    = (state != IDLE);
    assign miso_o    = (state == IDLE)  ? 1'bz :
                       (state == RDATA) ? shift_out[SPI_BYTE_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench: SPI master tasks drive frames, a monitor scores write-commit strobes.
module tb_spi_reg_responder;

    localparam int AW   = 3;
    localparam int HALF = 80;

    logic          Clk_i = 1'b0;
    logic          Rst_i = 1'b1;
    logic          sck_i = 1'b0;
    logic          mosi_i = 1'b0;
    logic [1:0]    ss_i = 2'b00;
    wire           miso_o;
    logic          lw_en_i = 1'b0;
    logic [AW-1:0] lw_addr_i = '0;
    logic [7:0]    lw_data_i = '0;
    logic [AW-1:0] rd_addr_i = '0;
    logic [7:0]    rd_data_o;
    logic          wr_pulse_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;
    logic          busy_o;

    // Released miso reads back as 1, so "z" is observable as a high level.
    pullup (miso_o);

    spi_reg_responder #(.ID(0), .AW(AW), .SYNC(2)) dut (
        .Clk_i(Clk_i), .Rst_i(Rst_i), .sck_i(sck_i), .mosi_i(mosi_i), .ss_i(ss_i),
        .miso_o(miso_o), .lw_en_i(lw_en_i), .lw_addr_i(lw_addr_i), .lw_data_i(lw_data_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .wr_pulse_o(wr_pulse_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    always #5 Clk_i = ~Clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk_i) begin
        if (wr_pulse_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_pulse_unexpected: got addr %0h data %0h expected none", wr_addr_o, wr_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_pulse", 32'({wr_addr_o, wr_data_o}), 32'({e.addr, e.data}));
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi_i = tx[7-i];
            #HALF;
            rx = {rx[6:0], miso_o};
            sck_i = 1'b1;
            #HALF;
            sck_i = 1'b0;
        end
    endtask

    task automatic frame_begin(input logic [1:0] ss);
        ss_i = ss;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        ss_i = 2'b00;
        #(2*HALF);
    endtask

    task automatic lw(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge Clk_i);
        lw_en_i = 1'b1; lw_addr_i = a; lw_data_i = d;
        @(negedge Clk_i);
        lw_en_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
        rd_addr_i = a;
        #1;
        chk(name, 32'(rd_data_o), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        repeat (4) @(negedge Clk_i);
        Rst_i = 1'b0;
        @(negedge Clk_i);

        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        chk("rst_miso_z", 32'(miso_o), 32'd1);
        for (int i = 0; i < 8; i++) rd_chk("rst_reg", AW'(i), 8'h00);

        // Single write
        frame_begin(2'b01);
        xfer(8'h03, 8, rx);
        chk("wr_cmd_miso", 32'(rx), 32'h00);
        chk("wr_busy", 32'(busy_o), 32'd1);
        push_wr(3'd3, 8'hA5);
        xfer(8'hA5, 8, rx);
        frame_end();
        rd_chk("wr_reg3", 3'd3, 8'hA5);

        // Read burst
        lw(3'd5, 8'h3C);
        lw(3'd6, 8'h5A);
        frame_begin(2'b01);
        xfer(8'h85, 8, rx);
        chk("rd_cmd_miso", 32'(rx), 32'h00);
        xfer(8'h00, 8, rx);
        chk("rd_byte0", 32'(rx), 32'h3C);
        xfer(8'h00, 8, rx);
        chk("rd_byte1", 32'(rx), 32'h5A);
        frame_end();

        // Write burst wrapping past the top address
        frame_begin(2'b01);
        xfer(8'h07, 8, rx);
        push_wr(3'd7, 8'h11); xfer(8'h11, 8, rx);
        push_wr(3'd0, 8'h22); xfer(8'h22, 8, rx);
        push_wr(3'd1, 8'h33); xfer(8'h33, 8, rx);
        frame_end();
        rd_chk("wrap_reg7", 3'd7, 8'h11);
        rd_chk("wrap_reg0", 3'd0, 8'h22);
        rd_chk("wrap_reg1", 3'd1, 8'h33);

        // Abort mid-byte, then a clean frame
        frame_begin(2'b01);
        xfer(8'h02, 8, rx);
        xfer(8'hFF, 4, rx);
        frame_end();
        chk("abort_busy", 32'(busy_o), 32'd0);
        rd_chk("abort_reg2", 3'd2, 8'h00);
        frame_begin(2'b01);
        xfer(8'h02, 8, rx);
        push_wr(3'd2, 8'h77);
        xfer(8'h77, 8, rx);
        frame_end();
        rd_chk("after_abort_reg2", 3'd2, 8'h77);

        // Other slave selected
        frame_begin(2'b10);
        xfer(8'h03, 8, rx);
        chk("desel_busy", 32'(busy_o), 32'd0);
        chk("desel_miso_cmd", 32'(rx), 32'hFF);
        xfer(8'h5A, 8, rx);
        chk("desel_miso_data", 32'(rx), 32'hFF);
        frame_end();
        rd_chk("desel_reg3", 3'd3, 8'hA5);

        // Reset in the middle of a read
        frame_begin(2'b01);
        xfer(8'h83, 8, rx);
        xfer(8'h00, 3, rx);
        chk("rst_pre_bits", 32'(rx), 32'h05);
        @(negedge Clk_i);
        Rst_i = 1'b1;
        @(negedge Clk_i);
        Rst_i = 1'b0;
        chk("midrst_miso_z", 32'(miso_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 8; i++) rd_chk("midrst_reg", AW'(i), 8'h00);
        xfer(8'h00, 5, rx);
        xfer(8'h03, 8, rx);
        xfer(8'h55, 8, rx);
        chk("rst_ign_miso", 32'(rx), 32'hFF);
        chk("rst_ign_busy", 32'(busy_o), 32'd0);
        frame_end();
        rd_chk("rst_ign_reg3", 3'd3, 8'h00);
        frame_begin(2'b01);
        xfer(8'h01, 8, rx);
        push_wr(3'd1, 8'h99);
        xfer(8'h99, 8, rx);
        frame_end();
        rd_chk("post_rst_reg1", 3'd1, 8'h99);

        repeat (4) @(negedge Clk_i);
        chk("wr_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
